ray_dir_reciprocal: RTL and testbench



---
 rtl/ray_dir_reciprocal_pkg.sv | 39 +++
 rtl/recip_div_lane.sv | 41 ++++
 rtl/ray_dir_reciprocal.sv | 154 +++++++++++++++
 tb/tb_ray_dir_reciprocal.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ray_dir_reciprocal_pkg.sv
// Shared types and constants for the ray-direction reciprocal precompute stage.
package ray_dir_reciprocal_pkg;

   localparam int FRAC_BITS     = 14;
   localparam int INV_FRAC_BITS = 18;
   localparam int VEC_W         = 28;
   localparam int INV_W         = 36;

   // Dividend is 2^(FRAC_BITS+INV_FRAC_BITS); one quotient bit per dividend bit.
   localparam int N_ITER_TRUNC  = FRAC_BITS + INV_FRAC_BITS + 1;
   localparam int N_ITER_ROUND  = N_ITER_TRUNC + 1;

`ifdef RECIP_ROUND_EN
   localparam int N_ITER        = N_ITER_ROUND;
`else
   localparam int N_ITER        = N_ITER_TRUNC;
`endif

   localparam int CNT_W         = $clog2(N_ITER_ROUND);

   typedef struct packed {
      logic signed [VEC_W-1:0] x;
      logic signed [VEC_W-1:0] y;
      logic signed [VEC_W-1:0] z;
   } vec3;

   typedef struct packed {
      logic signed [INV_W-1:0] x;
      logic signed [INV_W-1:0] y;
      logic signed [INV_W-1:0] z;
   } vec3_18_18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/recip_div_lane.sv
// One lane of an unsigned restoring divider computing 2^k / divisor, MSB first.
module recip_div_lane
   import ray_dir_reciprocal_pkg::*;
#(
   parameter int QW = N_ITER_TRUNC
) (
   input  logic             clk,
   input  logic             start_i,
   input  logic             en_i,
   input  logic [VEC_W-1:0] div_i,
   output logic [QW-1:0]    quot_o,
   output logic [VEC_W-1:0] rem_o
);

   logic [VEC_W-1:0] rem_q, rem_d;
   logic [QW-1:0]    quot_q, quot_d;
   logic [VEC_W:0]   shifted;
   logic             take;

   // The dividend is a single leading one followed by zeros, so the start step
   // shifts a 1 into an empty remainder and every later step shifts in a 0.
   always_comb begin
      shifted = start_i ? (VEC_W+1)'(1) : {rem_q, 1'b0};
      take    = (shifted >= {1'b0, div_i});
      rem_d   = rem_q;
      quot_d  = quot_q;
      if (start_i || en_i) begin
         rem_d  = take ? VEC_W'(shifted - {1'b0, div_i}) : VEC_W'(shifted);
         quot_d = start_i ? QW'(take) : {quot_q[QW-2:0], take};
      end
   end

   always_ff @(posedge clk) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
   end

   assign quot_o = quot_q;
   assign rem_o  = rem_q;

endmodule

// File: rtl/ray_dir_reciprocal.sv
// Per-axis reciprocal of a ray direction (Q13.14 -> Q17.18) with zero flags.
// Define RECIP_ROUND_EN for round-half-up (one extra quotient bit); default truncates.
module ray_dir_reciprocal
   import ray_dir_reciprocal_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  vec3        in_ray_orig,
   input  vec3        in_ray_dir,
   output logic       out_valid,
   input  logic       out_ready,
   output vec3        out_ray_orig,
   output vec3_18_18  out_inv_ray_dir,
   output logic [2:0] out_div_by_zero
);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    accept, iter_en, load_out;

   logic signed [VEC_W-1:0] dir_c    [3];
   logic [VEC_W-1:0]        mag_c    [3];
   logic [VEC_W-1:0]        mag_q    [3];
   logic [VEC_W-1:0]        lane_div [3];
   logic [N_ITER-1:0]       quot     [3];
   logic [VEC_W-1:0]        rem_unused [3];
   logic signed [INV_W-1:0] inv_c    [3];
   logic [2:0]              sign_q, dbz_q;
   vec3                     orig_q;

   vec3                     out_orig_q;
   vec3_18_18               out_inv_q;
   logic [2:0]              out_dbz_q;

   function automatic logic [VEC_W-1:0] abs_mag(input logic signed [VEC_W-1:0] d);
      return d[VEC_W-1] ? $unsigned(-d) : $unsigned(d);
   endfunction

   function automatic logic [INV_W-1:0] quot_to_mag(input logic [N_ITER-1:0] q);
`ifdef RECIP_ROUND_EN
      // q carries one extra fractional bit; adding half an LSB then dropping it rounds half up.
      return ({{(INV_W-N_ITER){1'b0}}, q} + INV_W'(1)) >> 1;
`else
      return {{(INV_W-N_ITER){1'b0}}, q};
`endif
   endfunction

   function automatic logic signed [INV_W-1:0] apply_sign(input logic [INV_W-1:0] m,
                                                           input logic neg);
      return neg ? -$signed(m) : $signed(m);
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept   = 1'b0;
      iter_en  = 1'b0;
      load_out = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = DIV;
               cnt_d   = '0;
            end
         end
         DIV: begin
            // The first quotient bit is produced on the accept edge, so the last
            // counter value is spent capturing the finished quotient.
            if (cnt_q == CNT_W'(N_ITER-1)) begin
               load_out = 1'b1;
               state_d  = DONE;
               cnt_d    = '0;
            end else begin
               iter_en = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dir_c[0] = in_ray_dir.x;
      dir_c[1] = in_ray_dir.y;
      dir_c[2] = in_ray_dir.z;
      for (int i = 0; i < 3; i++) begin
         mag_c[i]    = (dir_c[i] == '0) ? VEC_W'(1) : abs_mag(dir_c[i]);
         lane_div[i] = accept ? mag_c[i] : mag_q[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         inv_c[i] = dbz_q[i] ? '0 : apply_sign(quot_to_mag(quot[i]), sign_q[i]);
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_lane
      recip_div_lane #(
         .QW      (N_ITER)
      ) u_lane (
         .clk     (clk),
         .start_i (accept),
         .en_i    (iter_en),
         .div_i   (lane_div[g]),
         .quot_o  (quot[g]),
         .rem_o   (rem_unused[g])
      );
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         orig_q <= in_ray_orig;
         for (int i = 0; i < 3; i++) begin
            mag_q[i]  <= mag_c[i];
            sign_q[i] <= dir_c[i][VEC_W-1];
            dbz_q[i]  <= (dir_c[i] == '0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         out_orig_q <= '0;
         out_inv_q  <= '0;
         out_dbz_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load_out) begin
            out_orig_q  <= orig_q;
            out_inv_q.x <= inv_c[0];
            out_inv_q.y <= inv_c[1];
            out_inv_q.z <= inv_c[2];
            out_dbz_q   <= dbz_q;
         end
      end
   end

   assign in_ready        = (state_q == IDLE);
   assign out_valid       = (state_q == DONE);
   assign out_ray_orig    = out_orig_q;
   assign out_inv_ray_dir = out_inv_q;
   assign out_div_by_zero = out_dbz_q;

endmodule

// File: tb/tb_ray_dir_reciprocal.sv
// Directed bench for ray_dir_reciprocal: reciprocal values, zero lanes, stall, throughput, reset.
module tb_ray_dir_reciprocal;
   import ray_dir_reciprocal_pkg::*;

`ifdef RECIP_ROUND_EN
   localparam int    LAT  = 35;
   localparam longint Y15 = 174763;
`else
   localparam int    LAT  = 34;
   localparam longint Y15 = 174762;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   vec3        in_ray_orig, in_ray_dir, out_ray_orig;
   vec3_18_18  out_inv_ray_dir;
   logic [2:0] out_div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int lat, t1, t2;

   ray_dir_reciprocal dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_ray_orig     (in_ray_orig),
      .in_ray_dir      (in_ray_dir),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_ray_orig    (out_ray_orig),
      .out_inv_ray_dir (out_inv_ray_dir),
      .out_div_by_zero (out_div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic vec3 mk3(input int a, input int b, input int c);
      vec3 v;
      v.x = VEC_W'(a);
      v.y = VEC_W'(b);
      v.z = VEC_W'(c);
      return v;
   endfunction

   task automatic check_out(input string tag, input longint ex, input longint ey,
                            input longint ez, input logic [2:0] dz);
      chk({tag, ".inv.x"}, out_inv_ray_dir.x, ex);
      chk({tag, ".inv.y"}, out_inv_ray_dir.y, ey);
      chk({tag, ".inv.z"}, out_inv_ray_dir.z, ez);
      chk({tag, ".dbz"}, longint'(out_div_by_zero), longint'(dz));
   endtask

   // Called at a negedge; returns cycles from accept until out_valid is seen (-1 on timeout).
   task automatic send_and_wait(input vec3 orig, input vec3 dir, output int l);
      int k;
      for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
      in_ray_orig = orig;
      in_ray_dir  = dir;
      in_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      k = 1;
      while (!out_valid && k < 100) begin
         @(posedge clk);
         @(negedge clk);
         k++;
      end
      l = out_valid ? k : -1;
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".hs.out_valid"}, longint'(out_valid), 0);
      chk({tag, ".hs.in_ready"}, longint'(in_ready), 1);
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      in_ray_orig = '0;
      in_ray_dir  = '0;
      repeat (3) @(negedge clk);

      chk("rst.in_ready", longint'(in_ready), 1);
      chk("rst.out_valid", longint'(out_valid), 0);
      chk("rst.orig.x", out_ray_orig.x, 0);
      check_out("rst", 0, 0, 0, 3'b000);
      rst_n = 1'b1;
      @(negedge clk);

      // 1.0, -2.0, 3.0
      send_and_wait(mk3(100, 200, -300), mk3(16384, -32768, 49152), lat);
      chk("t1.latency", lat, LAT);
      check_out("t1", 262144, -131072, 87381, 3'b000);
      chk("t1.orig.z", out_ray_orig.z, -300);

      // Consumer stalls while a new ray is already offered.
      in_ray_dir = mk3(1, 1, 1);
      in_valid   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("stall.out_valid", longint'(out_valid), 1);
         chk("stall.in_ready", longint'(in_ready), 0);
         chk("stall.inv.y", out_inv_ray_dir.y, -131072);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("pulse.in_ready", longint'(in_ready), 1);
      chk("pulse.out_valid", longint'(out_valid), 0);
      in_valid = 1'b0;

      // Zero x lane, 1.5 and one LSB
      send_and_wait(mk3(1, 2, 3), mk3(0, 24576, 1), lat);
      chk("t2.latency", lat, LAT);
      check_out("t2", 0, Y15, 64'sd4294967296, 3'b001);
      handshake("t2");

      // Most negative direction component, origin passthrough
      send_and_wait(mk3(5, -7, 9), mk3(-134217728, 16384, -16384), lat);
      chk("t3.latency", lat, LAT);
      check_out("t3", -32, 262144, -262144, 3'b000);
      chk("t3.orig.x", out_ray_orig.x, 5);
      chk("t3.orig.y", out_ray_orig.y, -7);
      chk("t3.orig.z", out_ray_orig.z, 9);
      handshake("t3");

      // Back-to-back rays with the consumer always ready
      in_ray_orig = mk3(11, 22, 33);
      in_ray_dir  = mk3(16384, -32768, 49152);
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      t1 = -1;
      t2 = -1;
      for (int i = 0; i < 200 && t2 < 0; i++) begin
         if (in_ready) begin
            if (t1 < 0) t1 = cyc;
            else        t2 = cyc;
         end
         if (t2 < 0) @(negedge clk);
      end
      chk("b2b.spacing", t2 - t1, LAT + 1);
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // Reset during iteration 12 of the second ray
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("pre_rst.in_ready", longint'(in_ready), 0);
      chk("pre_rst.inv.x", out_inv_ray_dir.x, 262144);
      rst_n = 1'b0;
      #1;
      chk("mid_rst.in_ready", longint'(in_ready), 1);
      chk("mid_rst.out_valid", longint'(out_valid), 0);
      chk("mid_rst.orig.x", out_ray_orig.x, 0);
      check_out("mid_rst", 0, 0, 0, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      send_and_wait(mk3(-1, -2, -3), mk3(16384, 49152, 0), lat);
      chk("post.latency", lat, LAT);
      check_out("post", 262144, 87381, 0, 3'b100);
      chk("post.orig.y", out_ray_orig.y, -2);
      handshake("post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
